dna_window_loader: RTL and testbench
====================================

DNA_WINDOW_LOADER -- requirements
Module: dna_window_loader

Interface
REQ-001 Parameter WINDOW_BASES, default 32, number of 2-bit bases per window; data width SHALL be 2*WINDOW_BASES (64 at default).
REQ-002 Parameter POS_WIDTH, default 32, width of the window position counter.
REQ-003 clock  input  1  sole clock; all state SHALL update on the rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 base_in  input  2  nucleotide code (A=00, C=01, G=10, T=11).
REQ-006 base_valid  input  1  base_in valid this cycle.
REQ-007 base_ready  output  1  loader can accept a base; a transfer occurs when base_valid and base_ready are both high.
REQ-008 seq_start  input  1  qualified by transfer; the base is the first of a new sequence.
REQ-009 seq_end  input  1  qualified by transfer; the base is the last of the sequence.
REQ-010 hold  input  1  downstream stall request.
REQ-011 template_in  input  2*WINDOW_BASES  template pattern to capture.
REQ-012 template_load  input  1  capture template_in.
REQ-013 data  output  2*WINDOW_BASES  current window to the comparator; oldest base in the MSBs.
REQ-014 template  output  2*WINDOW_BASES  registered template to the comparator.
REQ-015 window_valid  output  1  one-cycle pulse; data holds a complete, newly advanced window.
REQ-016 position  output  POS_WIDTH  0-based sequence index of the oldest base in data; meaningful while window_valid is high.

Function
REQ-017 base_ready SHALL equal not hold and not reset (combinational).
REQ-018 The FSM SHALL have the states IDLE, FILL and STREAM.
REQ-019 IDLE: a transfer without seq_start SHALL be discarded with no state change; a transfer with seq_start SHALL go to FILL.
REQ-020 On every accepted base in FILL or STREAM (including a seq_start base), data SHALL become {data[2*WINDOW_BASES-3:0], base_in}.
REQ-021 A seq_start transfer in any state SHALL restart the sequence: fill count=1, base count=1, window_valid suppressed until the window refills.
REQ-022 FILL: a fill counter SHALL count accepted bases; the transfer making the count WINDOW_BASES SHALL move to STREAM.
REQ-023 window_valid SHALL be registered and pulse high exactly one cycle after each transfer that completes (FILL->STREAM) or advances (in STREAM) a full window; latency is 1 cycle.
REQ-024 position SHALL equal bases accepted in the current sequence minus WINDOW_BASES, registered with window_valid, and SHALL wrap modulo 2^POS_WIDTH.
REQ-025 A seq_end transfer SHALL be shifted in and produce window_valid if it completes a window, then go to IDLE.
REQ-026 seq_start and seq_end on the same transfer SHALL form a one-base sequence: go to IDLE with no window_valid unless WINDOW_BASES=1.
REQ-027 With hold high, no transfer occurs: data, counters and state SHALL be unchanged and window_valid SHALL be 0 the next cycle.
REQ-028 template_load SHALL capture template_in into template on the next edge only in IDLE; in FILL/STREAM it SHALL be ignored.
REQ-029 data SHALL remain stable between transfers.

Reset
REQ-030 While reset is high: state=IDLE; data, template, position and counters=0; window_valid=0; base_ready=0.
REQ-031 reset SHALL take priority over every other input, including mid-FILL or mid-STREAM, and no partial window SHALL survive it.

Verification
REQ-032 IDLE, template_load with template_in=64'h0123_4567_89AB_CDEF -> template=64'h0123_4567_89AB_CDEF next cycle; repeating in STREAM -> template unchanged.
REQ-033 seq_start on the first of 32 bases of 2'b01 -> window_valid pulses only the cycle after the 32nd transfer, data=64'h5555_5555_5555_5555, position=0.
REQ-034 A 33rd base 2'b11 -> one pulse, data=64'h5555_5555_5555_5557, position=1.
REQ-035 hold=1 for 3 cycles with base_valid=1 -> base_ready=0, data unchanged, no window_valid; on release, streaming resumes with position incremented by one per transfer.
REQ-036 seq_start mid-STREAM -> no window_valid for the next 31 transfers; the 32nd gives a pulse with position=0.
REQ-037 reset during FILL after 10 bases -> all outputs 0 and state IDLE; bases without seq_start are discarded and no window_valid follows.

Source files
------------

// File: rtl/dna_window_loader.sv
// -----------------------------------------------------------------------------
// dna_window_loader
//
// Purpose:
//   Turns a stream of 2-bit nucleotide codes into a sliding window of
//   WINDOW_BASES bases for a downstream pattern comparator. It also keeps
//   the comparison template, which can only be changed between sequences.
//   The window is a plain shift register: the newest base enters at the
//   LSBs and the oldest base sits in the MSBs. Once the window is full,
//   every accepted base advances it by one base and produces a one-cycle
//   window_valid pulse. The pulse carries the 0-based sequence index of
//   the oldest base in the window.
//
// Ports:
//   clock         in   sole clock, rising edge
//   reset         in   synchronous, active-high
//   base_in       in   [1:0] nucleotide code (A=00, C=01, G=10, T=11)
//   base_valid    in   base_in valid this cycle
//   base_ready    out  loader can accept a base (combinational)
//   seq_start     in   with a transfer: base is the first of a new sequence
//   seq_end       in   with a transfer: base is the last of the sequence
//   hold          in   downstream stall request; blocks all transfers
//   template_in   in   [2*WINDOW_BASES-1:0] template to capture
//   template_load in   capture template_in (honoured in IDLE only)
//   data          out  [2*WINDOW_BASES-1:0] current window, oldest in MSBs
//   template      out  [2*WINDOW_BASES-1:0] registered template
//   window_valid  out  one-cycle pulse: data is a full, newly advanced window
//   position      out  [POS_WIDTH-1:0] index of the oldest base in data
//   state_dbg     out  [1:0] FSM state (0=IDLE, 1=FILL, 2=STREAM)
//
// Handshake: a base transfers on a rising edge where base_valid and
// base_ready are both high. base_ready is simply !hold && !reset. It does
// not depend on base_valid, so a source can wait on it without creating a
// combinational loop. seq_start and seq_end only count on a transfer.
// -----------------------------------------------------------------------------
module dna_window_loader #(
  parameter int WINDOW_BASES = 32,
  parameter int POS_WIDTH    = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [1:0]                  base_in,
  input  logic                        base_valid,
  output logic                        base_ready,
  input  logic                        seq_start,
  input  logic                        seq_end,
  input  logic                        hold,
  input  logic [2*WINDOW_BASES-1:0]   template_in,
  input  logic                        template_load,
  output logic [2*WINDOW_BASES-1:0]   data,
  output logic [2*WINDOW_BASES-1:0]   template,
  output logic                        window_valid,
  output logic [POS_WIDTH-1:0]        position,
  output logic [1:0]                  state_dbg
);

  localparam int DW = 2 * WINDOW_BASES;
  // The fill counter must be able to hold the value WINDOW_BASES itself.
  localparam int FW = $clog2(WINDOW_BASES + 1);
  localparam logic [FW-1:0]        FILL_FULL = FW'(WINDOW_BASES);
  localparam logic [FW-1:0]        FILL_ONE  = FW'(1);
  localparam logic [POS_WIDTH-1:0] POS_ONE   = POS_WIDTH'(1);
  localparam logic [POS_WIDTH-1:0] POS_WIN   = POS_WIDTH'(WINDOW_BASES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [FW-1:0]        fill_cnt;
  logic [FW-1:0]        fill_nxt;
  logic [POS_WIDTH-1:0] base_cnt;
  logic [POS_WIDTH-1:0] base_nxt;
  logic                 xfer;
  logic                 accept;
  logic                 win_done;
  logic [DW-1:0]        data_shifted;

  assign xfer = base_valid && base_ready;

  // A one-base window has nothing to keep from the old contents.
  generate
    if (DW == 2) begin : g_shift_one
      assign data_shifted = base_in;
    end else begin : g_shift_many
      assign data_shifted = {data[DW-3:0], base_in};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and counter update
  // In IDLE, only a seq_start transfer is accepted; other transfers are
  // dropped. seq_start restarts the sequence from any state. STREAM keeps
  // the fill count at full, so every accepted base there completes a
  // window. seq_end always returns to IDLE, after the pulse decision has
  // been made, so the last base can still complete a window.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_cnt;
    base_nxt  = base_cnt;
    accept    = 1'b0;
    win_done  = 1'b0;
    if (xfer && (state != IDLE || seq_start)) begin
      accept = 1'b1;
      if (seq_start) begin
        fill_nxt = FILL_ONE;
        base_nxt = POS_ONE;
      end else begin
        base_nxt = base_cnt + POS_ONE;
        fill_nxt = (state == STREAM) ? FILL_FULL : fill_cnt + FILL_ONE;
      end
      win_done = (fill_nxt == FILL_FULL);
      if (seq_end) begin
        state_nxt = IDLE;
      end else if (win_done) begin
        state_nxt = STREAM;
      end else begin
        state_nxt = FILL;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    base_ready = !hold && !reset;
    state_dbg  = state;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      data         <= '0;
      template     <= '0;
      position     <= '0;
      window_valid <= 1'b0;
      fill_cnt     <= '0;
      base_cnt     <= '0;
    end else begin
      window_valid <= win_done;
      if (accept) begin
        data     <= data_shifted;
        fill_cnt <= fill_nxt;
        base_cnt <= base_nxt;
      end
      // base_nxt counts the new base, so this is the index of the oldest
      // base still in the window. It wraps with the counter width.
      if (win_done) begin
        position <= base_nxt - POS_WIN;
      end
      // The template stays frozen while the comparator is using it.
      if (template_load && state == IDLE) begin
        template <= template_in;
      end
    end
  end

endmodule

// File: tb/tb_dna_window_loader.sv
module tb_dna_window_loader;

  localparam int W  = 32;
  localparam int DW = 2 * W;
  localparam int PW = 32;

  logic          clock;
  logic          reset;
  logic [1:0]    base_in;
  logic          base_valid;
  logic          base_ready;
  logic          seq_start;
  logic          seq_end;
  logic          hold;
  logic [DW-1:0] template_in;
  logic          template_load;
  logic [DW-1:0] data;
  logic [DW-1:0] template;
  logic          window_valid;
  logic [PW-1:0] position;
  logic [1:0]    state_dbg;

  dna_window_loader #(.WINDOW_BASES(W), .POS_WIDTH(PW)) dut (
    .clock(clock),
    .reset(reset),
    .base_in(base_in),
    .base_valid(base_valid),
    .base_ready(base_ready),
    .seq_start(seq_start),
    .seq_end(seq_end),
    .hold(hold),
    .template_in(template_in),
    .template_load(template_load),
    .data(data),
    .template(template),
    .window_valid(window_valid),
    .position(position),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW+PW-1:0] exp_q[$];
  logic [DW+PW-1:0] mon_e;

  // Reference model state.
  logic [DW-1:0] m_win;
  logic [DW-1:0] m_tmpl;
  int unsigned   m_cnt;
  bit            m_in_seq;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Every window_valid pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (window_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_window got data %h pos %0d want none", data, position);
      end else begin
        mon_e = exp_q.pop_front();
        if ({data, position} !== mon_e) begin
          errors++;
          $display("FAIL window got data %h pos %0d want data %h pos %0d",
                   data, position, mon_e[DW+PW-1:PW], mon_e[PW-1:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [1:0] b, input logic st, input logic en,
                       input logic v, input logic h, input logic r,
                       input logic ld, input logic [DW-1:0] tin);
    base_in       = b;
    seq_start     = st;
    seq_end       = en;
    base_valid    = v;
    hold          = h;
    reset         = r;
    template_load = ld;
    template_in   = tin;
    #1;
    chk("base_ready", 64'(base_ready), 64'(!h && !r));
    if (r) begin
      m_win    = '0;
      m_tmpl   = '0;
      m_cnt    = 0;
      m_in_seq = 1'b0;
    end else begin
      if (ld && !m_in_seq) m_tmpl = tin;
      if (v && !h && (m_in_seq || st)) begin
        if (st) begin
          m_in_seq = 1'b1;
          m_cnt    = 0;
        end
        m_win = {m_win[DW-3:0], b};
        m_cnt++;
        if (m_cnt >= W) exp_q.push_back({m_win, PW'(m_cnt - W)});
        if (en) m_in_seq = 1'b0;
      end
    end
    @(posedge clock);
    #1;
    chk("data", data, m_win);
    chk("template", template, m_tmpl);
  endtask

  task automatic idle();
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic send(input logic [1:0] b, input logic st, input logic en);
    drive(b, st, en, 1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // ---------------- table ----------------
  typedef struct {
    logic          hold;
    logic          valid;
    logic [1:0]    base;
    logic          exp_wv;
    logic [PW-1:0] exp_pos;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // Three stalled cycles with valid high, then five transfers.
    for (int i = 0; i < 8; i++) begin
      tbl[i].hold    = (i < 3);
      tbl[i].valid   = 1'b1;
      tbl[i].base    = 2'($urandom_range(0, 3));
      tbl[i].exp_wv  = (i >= 3);
      tbl[i].exp_pos = (i >= 3) ? PW'(i - 1) : '0;
    end

    m_win = '0; m_tmpl = '0; m_cnt = 0; m_in_seq = 1'b0;

    // Reset, with a base offered so that any leak through reset would show.
    for (int i = 0; i < 3; i++) drive(2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, '1);
    chk("rst_wv", 64'(window_valid), 64'd0);
    chk("rst_pos", 64'(position), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'd0);
    idle();

    // Template capture in IDLE.
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF);
    chk("tmpl_idle", template, 64'h0123_4567_89AB_CDEF);

    // Fill with 32 bases of 01.
    for (int i = 0; i < W; i++) begin
      send(2'b01, i == 0, 1'b0);
      if (i == W - 2) chk("fill_no_wv", 64'(window_valid), 64'd0);
      if (i == 0) chk("fill_state", 64'(state_dbg), 64'd1);
    end
    chk("full_wv", 64'(window_valid), 64'd1);
    chk("full_data", data, 64'h5555_5555_5555_5555);
    chk("full_pos", 64'(position), 64'd0);
    chk("stream_state", 64'(state_dbg), 64'd2);

    // 33rd base.
    send(2'b11, 1'b0, 1'b0);
    chk("b33_wv", 64'(window_valid), 64'd1);
    chk("b33_data", data, 64'h5555_5555_5555_5557);
    chk("b33_pos", 64'(position), 64'd1);

    // A template load in STREAM is ignored.
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'hFEDC_BA98_7654_3210);
    chk("tmpl_stream", template, 64'h0123_4567_89AB_CDEF);
    chk("tmpl_stream_wv", 64'(window_valid), 64'd0);

    // Table: hold with valid high, then resume streaming.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].base, 1'b0, 1'b0, tbl[i].valid, tbl[i].hold, 1'b0, 1'b0, '0);
      chk("tbl_wv", 64'(window_valid), 64'(tbl[i].exp_wv));
      if (tbl[i].exp_wv) chk("tbl_pos", 64'(position), 64'(tbl[i].exp_pos));
    end

    // Restart mid-STREAM: 31 transfers with no pulse, a pulse on the 32nd.
    for (int i = 0; i < W; i++) begin
      send(2'($urandom_range(0, 3)), i == 0, 1'b0);
      if (i < W - 1) chk("restart_no_wv", 64'(window_valid), 64'd0);
    end
    chk("restart_wv", 64'(window_valid), 64'd1);
    chk("restart_pos", 64'(position), 64'd0);

    // seq_end completes a window and returns to IDLE.
    send(2'b10, 1'b0, 1'b1);
    chk("end_wv", 64'(window_valid), 64'd1);
    chk("end_pos", 64'(position), 64'd1);
    chk("end_state", 64'(state_dbg), 64'd0);

    // Bases without seq_start in IDLE are dropped.
    for (int i = 0; i < 3; i++) begin
      send(2'b11, 1'b0, 1'b0);
      chk("idle_drop_state", 64'(state_dbg), 64'd0);
    end

    // One-base sequence.
    send(2'b01, 1'b1, 1'b1);
    chk("one_base_wv", 64'(window_valid), 64'd0);
    chk("one_base_state", 64'(state_dbg), 64'd0);

    // Reset during FILL after 10 bases.
    for (int i = 0; i < 10; i++) send(2'($urandom_range(0, 3)), i == 0, 1'b0);
    chk("pre_rst_state", 64'(state_dbg), 64'd1);
    drive(2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    chk("mid_rst_data", data, 64'd0);
    chk("mid_rst_tmpl", template, 64'd0);
    chk("mid_rst_wv", 64'(window_valid), 64'd0);
    chk("mid_rst_pos", 64'(position), 64'd0);
    chk("mid_rst_state", 64'(state_dbg), 64'd0);
    for (int i = 0; i < 25; i++) begin
      send(2'($urandom_range(0, 3)), 1'b0, 1'b0);
      chk("post_rst_state", 64'(state_dbg), 64'd0);
    end

    idle();
    idle();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
